// File: rtl/fifo_word_packer.sv
// fifo_word_packer
// Drains bytes from an 8-bit synchronous FIFO read port and packs LANES
// consecutive bytes into one wide word for the systolic-array row feeder.
// The word leaves over a valid/ready handshake. A flush pulse forces out a
// zero-padded partial word at the end of a tile.
//
// Optional feature: define PACKER_WORD_CNT_EN to add the word_cnt output,
// a 16-bit wrapping count of words handed off since reset.
module fifo_word_packer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       fifo_dataout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic                    flush,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [3:0]              out_bytes,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef PACKER_WORD_CNT_EN
    ,
    output logic [15:0]             word_cnt
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Lane counts never exceed 8, so the 4-bit out_bytes width covers them.
    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);

    state_t                       state;
    logic [CNT_W-1:0]             fill_cnt;   // lanes already captured
    logic                         pend;       // read issued last cycle, data arrives now
    logic                         flush_req;  // partial word requested, draining pend
    logic [LANES-1:0][DATA_W-1:0] lane_q;     // lane 0 holds the first byte read
    logic [CNT_W-1:0]             occupied;   // captured lanes plus the one in flight
    logic                         handshake;

    // Lanes that are filled or already claimed by an outstanding read.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        occupied  = fill_cnt + CNT_W'(pend);
        handshake = out_valid && out_ready;
    end

    // Read request: only while collecting, with room left and no flush draining.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (rst && (state == FILL) && !fifo_empty && !flush_req && (occupied < LANES_C)) begin
            fifo_rd_en = 1'b1;
        end
    end

    // The lane register is the output word; unfilled lanes stay zero.
    assign out_data = lane_q;

    // Packing FSM: capture bytes in FILL, present the word in HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FILL;
            fill_cnt  <= '0;
            pend      <= 1'b0;
            flush_req <= 1'b0;
            // NOTE: the lane store is reset too; it doubles as out_data and must read 0 after reset.
            lane_q    <= '0;
            out_bytes <= '0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // branch below sees the pre-edge values of fill_cnt, pend and flush_req.
            pend <= fifo_rd_en;
            case (state)
                FILL: begin
                    if (pend) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (fill_cnt == CNT_W'(i)) begin
                                lane_q[i] <= fifo_dataout;
                            end
                        end
                        fill_cnt <= fill_cnt + CNT_W'(1);
                    end

                    if (pend && (occupied == LANES_C)) begin
                        // This capture completes the word; a coincident flush is absorbed.
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_bytes <= LANES_C;
                        flush_req <= 1'b0;
                    end else if (flush_req && !pend) begin
                        // Outstanding read has landed; emit what has been collected.
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_bytes <= fill_cnt;
                        flush_req <= 1'b0;
                    end else if (flush && (occupied != '0)) begin
                        // Flush with nothing collected or in flight would make an empty word.
                        flush_req <= 1'b1;
                    end
                end

                HOLD: begin
                    // Word, byte count and valid stay frozen until accepted; flush is ignored.
                    if (handshake) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        fill_cnt  <= '0;
                        lane_q    <= '0;
                    end
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

`ifdef PACKER_WORD_CNT_EN
    // Count of accepted words, partial ones included; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
        end else if (handshake) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
// Directed bench for fifo_word_packer with a behavioural 8-bit FIFO whose
// empty flag is registered in the same edge as the read. A negedge monitor
// collects accepted words and read/valid statistics for the test tasks.
// Build with PACKER_WORD_CNT_EN defined to include the word counter test.
module tb_fifo_word_packer;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;

    logic                    clk;
    logic                    rst;
    logic [DATA_W-1:0]       fifo_dataout;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic                    flush;
    logic [LANES*DATA_W-1:0] out_data;
    logic [3:0]              out_bytes;
    logic                    out_valid;
    logic                    out_ready;
`ifdef PACKER_WORD_CNT_EN
    logic [15:0]             word_cnt;
`endif

    // FIFO write side, driven by the tests
    logic                    wr_en;
    logic [DATA_W-1:0]       wr_data;
    logic [DATA_W-1:0]       fifo_mem[$];

    int n_cmp;
    int n_fail;

    // Monitor results
    logic [LANES*DATA_W-1:0] got_data[$];
    logic [3:0]              got_bytes[$];
    int rd_cnt, rd_run, max_run, valid_cycles, rd_in_hold, stab_err, underflow;
    logic                    prev_valid, prev_hs;
    logic [LANES*DATA_W-1:0] prev_data;
    logic [3:0]              prev_bytes;

    fifo_word_packer #(.LANES(LANES), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_dataout (fifo_dataout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .out_data     (out_data),
        .out_bytes    (out_bytes),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef PACKER_WORD_CNT_EN
        ,
        .word_cnt     (word_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural FIFO: data valid the cycle after a granted read, empty registered.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_mem.delete();
            fifo_empty   <= 1'b1;
            fifo_dataout <= '0;
        end else begin
            if (fifo_rd_en) begin
                if (fifo_mem.size() == 0) underflow <= underflow + 1;
                else                      fifo_dataout <= fifo_mem.pop_front();
            end
            if (wr_en) fifo_mem.push_back(wr_data);
            fifo_empty <= (fifo_mem.size() == 0);
        end
    end

    // Monitor: sample 1 time unit after the falling edge.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            if (fifo_rd_en) begin
                rd_cnt = rd_cnt + 1;
                rd_run = rd_run + 1;
                if (rd_run > max_run) max_run = rd_run;
            end else begin
                rd_run = 0;
            end
            if (out_valid) valid_cycles = valid_cycles + 1;
            if (out_valid && fifo_rd_en) rd_in_hold = rd_in_hold + 1;
            if (prev_valid && !prev_hs) begin
                if (out_valid !== 1'b1 || out_data !== prev_data || out_bytes !== prev_bytes)
                    stab_err = stab_err + 1;
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_bytes.push_back(out_bytes);
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            prev_data  = out_data;
            prev_bytes = out_bytes;
        end else begin
            rd_run     = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end
    end

    task automatic clear_mon();
        got_data.delete();
        got_bytes.delete();
        rd_cnt       = 0;
        rd_run       = 0;
        max_run      = 0;
        valid_cycles = 0;
        rd_in_hold   = 0;
        stab_err     = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input logic [DATA_W-1:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
    endtask

    task automatic push_stop();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Wait for n accepted words within a cycle budget; expiry counts as a failure.
    task automatic wait_words(input int n, input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #2;
            if (got_data.size() >= n) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: timeout, got %0d words, required %0d", name, got_data.size(), n);
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #2;
            if (out_valid === 1'b1) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for out_valid", name);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        underflow = 0;
        clear_mon();
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        idle(2);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", out_valid); end
        n_cmp++;
        if (out_bytes !== 4'd0) begin n_fail++; $display("FAIL reset_bytes: got %0d, required 0", out_bytes); end
        n_cmp++;
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, required 00000000", out_data); end
        n_cmp++;
        if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b, required 0", fifo_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        idle(3);
    endtask

    task automatic test_full_word();
        clear_mon();
        out_ready = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        push_stop();
        wait_words(1, 20, "full_word_wait");
        idle(3);
        n_cmp++;
        if (got_data.size() != 1 || got_data[0] !== 32'h44332211) begin
            n_fail++;
            $display("FAIL full_word_data: got %h (count %0d), required 44332211",
                     (got_data.size() > 0) ? got_data[0] : 32'h0, got_data.size());
        end
        n_cmp++;
        if (got_bytes.size() != 1 || got_bytes[0] !== 4'd4) begin
            n_fail++;
            $display("FAIL full_word_bytes: got %0d, required 4", (got_bytes.size() > 0) ? got_bytes[0] : 4'd0);
        end
        n_cmp++;
        if (valid_cycles != 1) begin n_fail++; $display("FAIL full_word_valid_len: got %0d cycles, required 1", valid_cycles); end
        n_cmp++;
        if (max_run != 4) begin n_fail++; $display("FAIL full_word_rd_run: got %0d, required 4", max_run); end
        n_cmp++;
        if (rd_cnt != 4) begin n_fail++; $display("FAIL full_word_rd_cnt: got %0d, required 4", rd_cnt); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] b;
        clear_mon();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            b = DATA_W'(i);
            push_byte(b);
        end
        push_stop();
        wait_valid(20, "bp_wait_valid");
        idle(10);
        #2;
        n_cmp++;
        if (out_data !== 32'h04030201 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_held_word: got %h valid %b, required 04030201 valid 1", out_data, out_valid);
        end
        n_cmp++;
        if (rd_cnt != 4) begin n_fail++; $display("FAIL bp_rd_while_hold: got %0d reads, required 4", rd_cnt); end
        @(negedge clk);
        out_ready = 1'b1;
        wait_words(2, 40, "bp_wait_words");
        idle(3);
        n_cmp++;
        if (got_data.size() != 2 || got_data[0] !== 32'h04030201 || got_data[1] !== 32'h08070605) begin
            n_fail++;
            $display("FAIL bp_words: got %0d words first %h, required 04030201 then 08070605",
                     got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0);
        end
        n_cmp++;
        if (got_bytes.size() != 2 || got_bytes[0] !== 4'd4 || got_bytes[1] !== 4'd4) begin
            n_fail++;
            $display("FAIL bp_bytes: got %0d words, required two with 4 bytes", got_bytes.size());
        end
        n_cmp++;
        if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled, required 0", stab_err); end
        n_cmp++;
        if (underflow != 0) begin n_fail++; $display("FAIL bp_underflow: got %0d, required 0", underflow); end
        n_cmp++;
        if (rd_in_hold != 0) begin n_fail++; $display("FAIL bp_rd_in_hold: got %0d, required 0", rd_in_hold); end
        n_cmp++;
        if (rd_cnt != 8) begin n_fail++; $display("FAIL bp_rd_cnt: got %0d, required 8", rd_cnt); end
    endtask

    task automatic test_flush_partial();
        clear_mon();
        out_ready = 1'b1;
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_stop();
        idle(4);
        pulse_flush();
        wait_words(1, 20, "flush_partial_wait");
        idle(2);
        n_cmp++;
        if (got_data.size() != 1 || got_data[0] !== 32'h0000BBAA) begin
            n_fail++;
            $display("FAIL flush_partial_data: got %h, required 0000bbaa", (got_data.size() > 0) ? got_data[0] : 32'h0);
        end
        n_cmp++;
        if (got_bytes.size() != 1 || got_bytes[0] !== 4'd2) begin
            n_fail++;
            $display("FAIL flush_partial_bytes: got %0d, required 2", (got_bytes.size() > 0) ? got_bytes[0] : 4'd0);
        end
    endtask

    task automatic test_flush_empty();
        clear_mon();
        out_ready = 1'b1;
        idle(2);
        pulse_flush();
        idle(12);
        n_cmp++;
        if (valid_cycles != 0) begin n_fail++; $display("FAIL flush_empty_valid: got %0d valid cycles, required 0", valid_cycles); end
        n_cmp++;
        if (got_data.size() != 0) begin n_fail++; $display("FAIL flush_empty_words: got %0d, required 0", got_data.size()); end
    endtask

    // Flush lands with two lanes filled and the third read outstanding.
    task automatic test_flush_pending();
        clear_mon();
        out_ready = 1'b1;
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        push_stop();
        pulse_flush();
        wait_words(1, 20, "flush_pend_wait");
        idle(2);
        n_cmp++;
        if (got_data.size() != 1 || got_data[0] !== 32'h00C3C2C1) begin
            n_fail++;
            $display("FAIL flush_pend_data: got %h, required 00c3c2c1", (got_data.size() > 0) ? got_data[0] : 32'h0);
        end
        n_cmp++;
        if (got_bytes.size() != 1 || got_bytes[0] !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_pend_bytes: got %0d, required 3", (got_bytes.size() > 0) ? got_bytes[0] : 4'd0);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        out_ready = 1'b1;
        push_byte(8'hD1);
        push_byte(8'hD2);
        push_stop();
        idle(4);
        async_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, required 0", out_valid); end
        n_cmp++;
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h, required 00000000", out_data); end
        n_cmp++;
        if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rd_en: got %b, required 0", fifo_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        clear_mon();
        push_byte(8'hE1);
        push_byte(8'hE2);
        push_byte(8'hE3);
        push_byte(8'hE4);
        push_stop();
        wait_words(1, 20, "rst_mid_wait");
        idle(2);
        n_cmp++;
        if (got_data.size() != 1 || got_data[0] !== 32'hE4E3E2E1 || got_bytes[0] !== 4'd4) begin
            n_fail++;
            $display("FAIL rst_mid_clean_word: got %h, required e4e3e2e1 with 4 bytes",
                     (got_data.size() > 0) ? got_data[0] : 32'h0);
        end

        // Reset while a word is held: valid must drop at once and the word is lost.
        clear_mon();
        out_ready = 1'b0;
        push_byte(8'hF1);
        push_byte(8'hF2);
        push_byte(8'hF3);
        push_byte(8'hF4);
        push_stop();
        wait_valid(20, "rst_hold_wait");
        async_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid: got %b, required 0", out_valid); end
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        idle(10);
        n_cmp++;
        if (got_data.size() != 0) begin n_fail++; $display("FAIL rst_hold_discard: got %0d words, required 0", got_data.size()); end
    endtask

`ifdef PACKER_WORD_CNT_EN
    task automatic test_word_cnt();
        logic [DATA_W-1:0] b;
        async_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL word_cnt_reset: got %0d, required 0", word_cnt); end
        clear_mon();
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 4; i++) begin
                b = DATA_W'(16 * w + i);
                push_byte(b);
            end
            push_stop();
            wait_words(w + 1, 20, "word_cnt_full_wait");
        end
        push_byte(8'h5A);
        push_byte(8'h5B);
        push_stop();
        idle(4);
        pulse_flush();
        wait_words(4, 20, "word_cnt_flush_wait");
        idle(2);
        n_cmp++;
        if (word_cnt !== 16'd4) begin n_fail++; $display("FAIL word_cnt_total: got %0d, required 4", word_cnt); end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_flush_pending();
        test_reset_mid();
`ifdef PACKER_WORD_CNT_EN
        test_word_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the 8-bit synchronous FIFO.
- Drains bytes from the FIFO read port and packs LANES consecutive bytes into one wide word.
- Presents the word to the systolic-array row feeder over a valid/ready handshake.
- A flush input emits a zero-padded partial word at the end of a tile.

Parameters:
- LANES, 4, bytes packed per output word (2..8).
- DATA_W, 8, byte width; must match the FIFO data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- fifo_dataout  input  DATA_W  FIFO read data; valid the cycle after a granted read.
- fifo_empty  input  1  FIFO empty flag, registered.
- fifo_rd_en  output  1  read request to the FIFO; combinational.
- flush  input  1  single-cycle pulse; forces out a partial word.
- out_data  output  LANES*DATA_W  packed word; lane 0 = first byte read, in bits [DATA_W-1:0].
- out_bytes  output  4  number of valid lanes in out_data (1..LANES).
- out_valid  output  1  out_data/out_bytes valid.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Behaviour:
- Reset (rst=0, async): state=FILL, fill_cnt=0, pend=0, flush_req=0, out_data=0, out_bytes=0, out_valid=0. fifo_rd_en is forced 0 while rst=0.
- States: FILL (collecting bytes) and HOLD (word presented).
- fifo_rd_en = (state==FILL) && !fifo_empty && !flush_req && (fill_cnt + pend < LANES).
- pend <= fifo_rd_en, registered. It marks a read whose data appears on fifo_dataout in the following cycle.
- Capture: when pend=1, the lane at index fill_cnt takes fifo_dataout and fill_cnt increments.
- Throughput is 1 byte/cycle; back-to-back reads are issued while room remains.
- FILL->HOLD, full word: the edge where a capture makes fill_cnt==LANES. Then out_valid<=1, out_bytes<=LANES, and the word is registered in the same edge.
- Flush:
  - A flush pulse in FILL sets flush_req if fill_cnt+pend>0; otherwise it is ignored (no empty word is emitted).
  - While flush_req=1, no new reads are issued.
  - Once pend=0 (the outstanding read has been captured), go to HOLD with out_bytes=fill_cnt. Unfilled lanes are 0.
  - flush_req then clears.
  - A flush arriving in the same cycle as the capture that completes a full word is absorbed; no extra word is emitted.
  - A flush in HOLD is ignored.
- HOLD:
  - out_data, out_bytes and out_valid stay stable until out_valid && out_ready.
  - On the handshake edge: out_valid<=0, fill_cnt<=0, lanes cleared to 0, state->FILL.
  - fifo_rd_en is 0 in HOLD, so there is one bubble cycle per word.
- FIFO contract: the FIFO's empty is registered in the same edge as its read. A read requested with fifo_empty=0 is therefore always granted; the packer never reads when empty.
- Reset mid-operation: all partial data and any pending read are discarded. The FIFO is reset by the same rst domain.

Optional Feature:
- Macro: PACKER_WORD_CNT_EN.
- Defined:
  - Adds output word_cnt[15:0]: the number of words handed off (handshakes) since reset.
  - Wraps 0xFFFF->0; reset value 0.
  - Partial (flushed) words count.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Write 0x11,0x22,0x33,0x44 to the FIFO, out_ready=1 -> one word out_data=0x44332211, out_bytes=4, out_valid high 1 cycle; fifo_rd_en high 4 consecutive cycles.
- Write 8 bytes 0x01..0x08, out_ready=0 for 10 cycles then 1 -> word 0x04030201 is held stable the whole time; 0x08070605 follows after one bubble cycle; the FIFO never underflows.
- Write 0xAA,0xBB then flush -> out_data=0x0000BBAA, out_bytes=2.
- flush with the FIFO empty and fill_cnt=0 -> no out_valid, ever.
- Flush asserted the cycle after fifo_rd_en (pend=1) with 2 bytes captured -> the third byte is captured first; out_bytes=3.
- Assert rst=0 asynchronously mid-word (2 lanes filled) -> out_valid=0 immediately; the next 4 bytes form a clean word with no stale lanes.
- With PACKER_WORD_CNT_EN: 3 full words + 1 flushed word -> word_cnt=4.
